// File: rtl/sine_top.sv
// Free-running 512-sample sine generator for a 10-bit resistor-ladder DAC.
// Define SINE_TEST_RAMP_EN to replace the sine with a {idx,0} sawtooth for DAC linearity tests.
module sine_top #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset,
   output logic _9b,
   output logic _6a,
   output logic _4a,
   output logic _2a,
   output logic _0a,
   output logic _5a,
   output logic _3b,
   output logic _49a,
   output logic _45a,
   output logic _48b
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

   logic [8:0]    idx;
   logic [CW-1:0] div_cnt;
   logic [9:0]    out;
   logic [9:0]    sample;

`ifdef SINE_TEST_RAMP_EN
   assign sample = {idx, 1'b0};
`else
   // pi in Q30; the quarter-wave table is evaluated at elaboration by a Taylor series.
   localparam longint PI_Q30 = 64'sd3373259426;

   function automatic logic [8:0] mag_f(input int i);
      longint x, x2, term, acc;
      x    = (PI_Q30 * longint'(2 * i + 1)) / 512;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n <= 10; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      return 9'((511 * acc + (longint'(1) <<< 29)) >>> 30);
   endfunction

   logic [8:0] rom [128];
   for (genvar g = 0; g < 128; g++) begin : g_rom
      localparam logic [8:0] MAG = mag_f(g);
      assign rom[g] = MAG;
   end

   logic [6:0] rom_addr;
   logic [9:0] mag;
   // Odd quadrants read the table backwards (127-a == ~a); upper half mirrors below midscale.
   assign rom_addr = idx[7] ? ~idx[6:0] : idx[6:0];
   assign mag      = {1'b0, rom[rom_addr]};
   assign sample   = idx[8] ? (10'd511 - mag) : (10'd512 + mag);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         idx     <= '0;
         div_cnt <= '0;
         out     <= 10'd512;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         idx     <= idx + 9'd1;
         out     <= sample;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign {_9b, _6a, _4a, _2a, _0a, _5a, _3b, _49a, _45a, _48b} = out;

endmodule

// File: tb/tb_sine_top.sv
// Directed bench for sine_top: DIV=1 and DIV=4 instances sharing one clock.
module tb_sine_top;

   logic clk = 1'b0;
   logic r1  = 1'b1;
   logic r4  = 1'b1;
   always #5 clk = ~clk;

   logic a9b, a6a, a4a, a2a, a0a, a5a, a3b, a49a, a45a, a48b;
   logic b9b, b6a, b4a, b2a, b0a, b5a, b3b, b49a, b45a, b48b;
   logic [9:0] p1, p4;
   assign p1 = {a9b, a6a, a4a, a2a, a0a, a5a, a3b, a49a, a45a, a48b};
   assign p4 = {b9b, b6a, b4a, b2a, b0a, b5a, b3b, b49a, b45a, b48b};

   sine_top #(.DIV(1)) dut1 (
      .clk(clk), .reset(r1),
      ._9b(a9b), ._6a(a6a), ._4a(a4a), ._2a(a2a), ._0a(a0a),
      ._5a(a5a), ._3b(a3b), ._49a(a49a), ._45a(a45a), ._48b(a48b)
   );

   sine_top #(.DIV(4)) dut4 (
      .clk(clk), .reset(r4),
      ._9b(b9b), ._6a(b6a), ._4a(b4a), ._2a(b2a), ._0a(b0a),
      ._5a(b5a), ._3b(b3b), ._49a(b49a), ._45a(b45a), ._48b(b48b)
   );

`ifdef SINE_TEST_RAMP_EN
   localparam int S0 = 0;
   localparam int S1 = 2;
`else
   localparam int S0 = 515;
   localparam int S1 = 521;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int s [1250];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   initial begin
      int mx, mn;
      repeat (5) tick();
      check("reset_mid", int'(p1), 512);
      check("reset_mid4", int'(p4), 512);

      // DIV=1: capture 1250 consecutive samples after release
      r1 = 1'b0;
      for (int k = 0; k < 1250; k++) begin
         tick();
         s[k] = int'(p1);
      end
      check("first", s[0], S0);
      check("second", s[1], S1);

`ifdef SINE_TEST_RAMP_EN
      for (int k = 0; k < 512; k++) check("ramp", s[k], 2 * k);
      check("ramp_wrap", s[512], 0);
      for (int k = 0; k < 1250; k++) check("lsb_zero", s[k] % 2, 0);
`else
      check("idx63", s[63], 871);
      check("idx64", s[64], 876);
      check("idx127", s[127], 1023);
      check("idx128", s[128], 1023);
      check("idx255", s[255], 515);
      check("idx256", s[256], 508);
      check("idx383", s[383], 0);
      check("idx384", s[384], 0);
      check("idx511", s[511], 508);
      check("wrap512", s[512], 515);
      for (int k = 0; k < 256; k++) check("sym_half", s[k] + s[k + 256], 1023);
      for (int k = 0; k < 128; k++) check("sym_quarter", s[k], s[255 - k]);
      for (int k = 0; k < 127; k++) check("rising_q0", int'(s[k + 1] >= s[k]), 1);
      mx = 0;
      mn = 1023;
      for (int k = 0; k < 512; k++) begin
         if (s[k] > mx) mx = s[k];
         if (s[k] < mn) mn = s[k];
      end
      check("max", mx, 1023);
      check("min", mn, 0);
`endif
      for (int k = 512; k < 1250; k++) check("period", s[k], s[k - 512]);

      // One-clock reset mid-period restarts at idx 0
      r1 = 1'b1;
      tick();
      check("midreset", int'(p1), 512);
      r1 = 1'b0;
      tick();
      check("restart0", int'(p1), S0);
      tick();
      check("restart1", int'(p1), S1);

      // DIV=4: first sample on the 4th edge, each held 4 clocks
      r4 = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         check("div4_pre", int'(p4), 512);
      end
      tick();
      check("div4_first", int'(p4), S0);
      for (int e = 5; e <= 7; e++) begin
         tick();
         check("div4_hold", int'(p4), S0);
      end
      tick();
      check("div4_second", int'(p4), S1);
      repeat (2040) tick();
      check("div4_e2048", int'(p4), (S0 == 0) ? 1022 : 508);
      repeat (3) tick();
      check("div4_e2051", int'(p4), (S0 == 0) ? 1022 : 508);
      tick();
      check("div4_wrap", int'(p4), S0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
